// File: rtl/wr_en_decoder_pkg.sv
// Shared types and helpers for the register-file write-enable decoder.
// Holds the sweep FSM state encoding and the per-port address slice helper.
package wr_en_decoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_PORTS  = 4;

  // Extract port p's address field of width w from a packed address bus.
  function automatic logic [MAX_ADDR_W-1:0] port_addr(
    input logic [MAX_PORTS*MAX_ADDR_W-1:0] bus,
    input int                              p,
    input int                              w
  );
    logic [MAX_PORTS*MAX_ADDR_W-1:0] shifted;
    logic [MAX_ADDR_W-1:0]           mask;
    shifted = bus >> (p * w);
    mask    = MAX_ADDR_W'((33'd1 << w) - 33'd1);
    return shifted[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/wr_en_decoder_onehot_dec.sv
// Binary-to-one-hot decoder with enable; output is all zero when disabled.
module onehot_dec
  import wr_en_decoder_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]    sel,
  input  logic                 enable,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/wr_en_decoder.sv
// Registered write-enable decoder: multi-port fixed-priority writes plus a
// clear-sweep sequencer that loads every register once, one per cycle.
module wr_en_decoder
  import wr_en_decoder_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int PORTS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS*ADDR_W-1:0] addr,
  input  logic [PORTS-1:0]        en,
  input  logic                    clr_start,
  output logic [2**ADDR_W-1:0]    ld,
  output logic [PORTS-1:0]        grant,
  output logic                    collision,
  output logic                    drop,
  output logic                    busy,
  output logic                    clr_done,
  output state_e                  state_dbg
);

  localparam int                REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REGS - 1);

  // Request/acknowledge: en[p] is a one-cycle write request with no retry;
  // grant[p] one cycle later says it was written, otherwise it is lost.
  state_e            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [REGS-1:0]   ld_n;
  logic [PORTS-1:0]  grant_n;
  logic              collision_n, drop_n, busy_n, clr_done_n;

  logic [MAX_PORTS*MAX_ADDR_W-1:0] addr_ext;
  logic [ADDR_W-1:0]               port_sel [PORTS];
  logic [REGS-1:0]                 port_oh  [PORTS];

  always_comb begin
    addr_ext                     = '0;
    addr_ext[PORTS*ADDR_W-1:0]   = addr;
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [MAX_ADDR_W-1:0] sel_full;
    assign sel_full    = port_addr(addr_ext, p, ADDR_W);
    assign port_sel[p] = sel_full[ADDR_W-1:0];
    onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .sel    (port_sel[p]),
      .enable (en[p]),
      .onehot (port_oh[p])
    );
  end

  // A port loses to any lower-index enabled port aiming at the same register.
  logic [PORTS-1:0] gnt_c;
  logic             lost_c;
  logic [REGS-1:0]  ld_req;

  always_comb begin
    gnt_c  = en;
    lost_c = 1'b0;
    ld_req = '0;
    for (int p = 1; p < PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (en[q] && en[p] && (port_sel[q] == port_sel[p])) gnt_c[p] = 1'b0;
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      if (gnt_c[p]) ld_req = ld_req | port_oh[p];
      if (en[p] && !gnt_c[p]) lost_c = 1'b1;
    end
  end

  // cnt holds the index of the next sweep load; it rests at 0 in IDLE.
  logic            sweep_en;
  logic [REGS-1:0] sweep_oh;

  assign sweep_en = clr_start || (state == SWEEP);

  onehot_dec #(.ADDR_W(ADDR_W)) u_sweep_dec (
    .sel    (cnt),
    .enable (sweep_en),
    .onehot (sweep_oh)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ld_n        = '0;
    grant_n     = '0;
    collision_n = 1'b0;
    drop_n      = 1'b0;
    busy_n      = 1'b0;
    clr_done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_n = SWEEP;
          cnt_n   = cnt + 1'b1;
          ld_n    = sweep_oh;
          busy_n  = 1'b1;
          drop_n  = |en;
        end else begin
          ld_n        = ld_req;
          grant_n     = gnt_c;
          collision_n = lost_c;
        end
      end
      SWEEP: begin
        cnt_n  = cnt + 1'b1;
        ld_n   = sweep_oh;
        busy_n = 1'b1;
        drop_n = |en;
        if (cnt == LAST) begin
          clr_done_n = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ld        <= '0;
      grant     <= '0;
      collision <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ld        <= ld_n;
      grant     <= grant_n;
      collision <= collision_n;
      drop      <= drop_n;
      busy      <= busy_n;
      clr_done  <= clr_done_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/wr_en_decoder.md
# wr_en_decoder

Parametrised, registered write-enable decoder for the register file. It generalises the single 3-to-8 enable decoder to 2^ADDR_W registers and PORTS independent write ports. It adds fixed-priority collision resolution and a built-in clear-sweep sequencer that loads every register once, one per cycle. It sits between the control unit and the register file load inputs.

## Interface
- ADDR_W, default 3: register address width; REGS = 2**ADDR_W (local, not overridable).
- PORTS, default 2: number of write ports, 1..4.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- addr  in  PORTS*ADDR_W  write address per port; port p occupies bits [p*ADDR_W +: ADDR_W].
- en  in  PORTS  write request per port.
- clr_start  in  1  request a clear sweep of all registers.
- ld  out  REGS  registered load enables to the register file.
- grant  out  PORTS  registered; port p's write was accepted this cycle.
- collision  out  1  registered; two or more enabled ports targeted the same address.
- drop  out  1  registered; at least one en bit was ignored because of a sweep.
- busy  out  1  registered; sweep in progress.
- clr_done  out  1  registered single-cycle pulse on the last sweep load.

## Operation
- States: IDLE, SWEEP. Reset → IDLE, sweep counter 0, every output 0.
- IDLE, clr_start=0: each enabled port decodes its addr to one-hot.
- Ports are resolved lowest index first. A port is granted only if no lower-index enabled port has the same addr.
- ld = OR of the one-hots of granted ports. grant = granted ports. collision = 1 if any enabled port lost.
- en=0 everywhere → ld=0, grant=0, collision=0.
- IDLE, clr_start=1: go to SWEEP with counter=0. clr_start takes priority over en. Any en bit set that cycle → drop=1, no grant.
- SWEEP: ld = one-hot(counter), grant=0, collision=0, busy=1. The counter increments each cycle.
- SWEEP, counter = REGS-1: clr_done=1, then return to IDLE. The counter wraps to 0.
- SWEEP with any en bit set → drop=1 for that cycle; requests are discarded, not queued.
- clr_start during SWEEP: ignored; the sweep does not restart.
- Reset during SWEEP: abort immediately to IDLE; ld, busy, clr_done go to 0 asynchronously.
- Counter width is ADDR_W. No overflow beyond REGS-1 is possible.

## Timing
- Latency 1: inputs sampled at edge T appear on ld/grant/collision/drop after edge T.
- Sweep started by clr_start sampled at edge T:
  - ld = one-hot(k) during cycle T+1+k, for k = 0..REGS-1.
  - busy = 1 for cycles T+1..T+REGS.
  - clr_done = 1 only in cycle T+REGS.
  - New port requests can be granted again when sampled at edge T+REGS.
- Back-to-back writes: a new set of grants is possible every cycle in IDLE.
- No combinational path from inputs to outputs.

## Structure
- Shared package: state enum (IDLE, SWEEP) and the port-address slice helper.
- One sub-module, onehot_dec: parameter ADDR_W; inputs sel and enable; output 2**ADDR_W one-hot, all zero when disabled.
- Instantiate onehot_dec once per port and once for the sweep counter.
- Priority resolution, state register and output registers live in the top module.

## Test plan
- Reset: assert reset mid-cycle with en=2'b11 → all outputs 0 immediately, state IDLE.
- Distinct writes (ADDR_W=3, PORTS=2): addr0=3, addr1=5, en=2'b11 → next cycle ld=8'b0010_1000, grant=2'b11, collision=0.
- Collision: addr0=addr1=6, en=2'b11 → ld=8'b0100_0000, grant=2'b01, collision=1.
- Sweep: pulse clr_start at edge T → ld walks 0x01, 0x02, … 0x80 over cycles T+1..T+8; clr_done only at T+8; busy falls at T+9.
- Sweep interference:
  - en=2'b01 at T+3 → drop=1 at T+4, ld unaffected.
  - clr_start at T+5 → ignored.
- Reset at sweep step 4 → outputs 0. A later clr_start restarts from ld=0x01.
